receiver_timing_control: RTL and testbench

RECEIVER_TIMING_CONTROL -- requirements
Module: receiver_timing_control

---
 rtl/receiver_timing_control_if.sv | 31 +++
 rtl/receiver_timing_control.sv | 169 ++++++++++++++++
 tb/tb_receiver_timing_control.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/receiver_timing_control_if.sv
// Receiver bus interface: serial line and consumer handshake in, byte and status out.
//   rx            serial line, idle high, asynchronous to BCLK
//   rx_ack        consumer has taken rx_data (pulse or level)
//   rx_data       last received byte, LSB = first data bit
//   data_ready    unread byte present in rx_data
//   framing_error stop bit of last completed frame sampled low
//   overrun_error a frame completed while data_ready was still set
//   rx_busy       frame reception in progress
interface receiver_timing_control_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 rx;
  logic                 rx_ack;
  logic [DATA_BITS-1:0] rx_data;
  logic                 data_ready;
  logic                 framing_error;
  logic                 overrun_error;
  logic                 rx_busy;

  // Line/consumer side.
  modport master (
    output rx, rx_ack,
    input  rx_data, data_ready, framing_error, overrun_error, rx_busy
  );

  // Receiver side.
  modport slave (
    input  rx, rx_ack,
    output rx_data, data_ready, framing_error, overrun_error, rx_busy
  );
endinterface

// File: rtl/receiver_timing_control.sv
// Oversampling serial receiver timing control.
// Synchronizes rx, finds the start bit at its mid-point, samples each data and
// stop bit once per bit time, and publishes the byte with ready/error flags.
// Ports:
//   BCLK  oversampling clock (OVERSAMPLE cycles per bit)
//   RST   asynchronous active-high reset
//   bus   receiver_timing_control_if.slave (rx, rx_ack in; rx_data and flags out)
module receiver_timing_control #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8
) (
  input  logic                       BCLK,
  input  logic                       RST,
  receiver_timing_control_if.slave   bus
);

  localparam int unsigned SCNT_W = $clog2(OVERSAMPLE);
  localparam int unsigned BCNT_W = $clog2(DATA_BITS);

  localparam logic [SCNT_W-1:0] SCNT_HALF = SCNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(OVERSAMPLE - 1);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [SCNT_W-1:0]    scnt_q, scnt_d;
  logic [BCNT_W-1:0]    bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 ready_q, ready_d;
  logic                 ferr_q, ferr_d;
  logic                 oerr_q, oerr_d;
  logic                 busy_q, busy_d;
  logic [1:0]           sync_q;
  logic                 rx_s;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge BCLK or posedge RST) begin
    if (RST) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], bus.rx};
    end
  end

  assign rx_s = sync_q[1];

  // State and datapath registers.
  always_ff @(posedge BCLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      scnt_q    <= '0;
      bcnt_q    <= '0;
      shift_q   <= '0;
      rx_data_q <= '0;
      ready_q   <= 1'b0;
      ferr_q    <= 1'b0;
      oerr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      scnt_q    <= scnt_d;
      bcnt_q    <= bcnt_d;
      shift_q   <= shift_d;
      rx_data_q <= rx_data_d;
      ready_q   <= ready_d;
      ferr_q    <= ferr_d;
      oerr_q    <= oerr_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d   = state_q;
    scnt_d    = scnt_q;
    bcnt_d    = bcnt_q;
    shift_d   = shift_q;
    rx_data_d = rx_data_q;
    ready_d   = ready_q;
    ferr_d    = ferr_q;
    oerr_d    = oerr_q;

    // Consumer acknowledge; a completing frame below takes priority.
    if (bus.rx_ack) begin
      ready_d = 1'b0;
      oerr_d  = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          scnt_d  = '0;
        end
      end

      // Re-check the line at the start bit mid-point to reject glitches.
      S_START: begin
        if (scnt_q == SCNT_HALF) begin
          scnt_d = '0;
          if (!rx_s) begin
            state_d = S_DATA;
            bcnt_d  = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          scnt_d = scnt_q + SCNT_W'(1);
        end
      end

      // Bits arrive LSB first, so shifting in at the MSB leaves the byte right-aligned.
      S_DATA: begin
        if (scnt_q == SCNT_LAST) begin
          scnt_d  = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          if (bcnt_q == BCNT_LAST) begin
            state_d = S_STOP;
          end else begin
            bcnt_d = bcnt_q + BCNT_W'(1);
          end
        end else begin
          scnt_d = scnt_q + SCNT_W'(1);
        end
      end

      S_STOP: begin
        if (scnt_q == SCNT_LAST) begin
          scnt_d    = '0;
          rx_data_d = shift_q;
          ferr_d    = !rx_s;
          ready_d   = 1'b1;
          oerr_d    = ready_q && !bus.rx_ack;
          state_d   = rx_s ? S_IDLE : S_BREAK;
        end else begin
          scnt_d = scnt_q + SCNT_W'(1);
        end
      end

      // Held-low line after a bad stop bit; wait for idle before rearming.
      S_BREAK: begin
        if (rx_s) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign bus.rx_data       = rx_data_q;
  assign bus.data_ready    = ready_q;
  assign bus.framing_error = ferr_q;
  assign bus.overrun_error = oerr_q;
  assign bus.rx_busy       = busy_q;

endmodule

// File: tb/tb_receiver_timing_control.sv
// Testbench for receiver_timing_control: directed and randomized frames checked
// against a frame-level reference model of the output flags.
module tb_receiver_timing_control;

  localparam int unsigned OS  = 16;
  localparam int unsigned DB  = 8;
  localparam int unsigned DONE_EDGE = (DB + 1) * OS + OS / 2 + 2;

  logic BCLK;
  logic RST;

  receiver_timing_control_if #(.DATA_BITS(DB)) bus ();

  receiver_timing_control #(
    .OVERSAMPLE (OS),
    .DATA_BITS  (DB)
  ) dut (
    .BCLK (BCLK),
    .RST  (RST),
    .bus  (bus)
  );

  initial BCLK = 1'b0;
  always #5 BCLK = ~BCLK;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state: what the outputs must show at frame level.
  logic [DB-1:0] exp_data;
  logic          exp_dr;
  logic          exp_fe;
  logic          exp_ov;

  task automatic tick();
    @(posedge BCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".data"}, 32'(bus.rx_data), 32'(exp_data));
    check({tag, ".dr"},   32'(bus.data_ready), 32'(exp_dr));
    check({tag, ".fe"},   32'(bus.framing_error), 32'(exp_fe));
    check({tag, ".ov"},   32'(bus.overrun_error), 32'(exp_ov));
  endtask

  task automatic model_reset();
    exp_data = '0;
    exp_dr   = 1'b0;
    exp_fe   = 1'b0;
    exp_ov   = 1'b0;
  endtask

  // Single-cycle acknowledge outside any frame completion.
  task automatic do_ack(input string tag);
    bus.rx_ack = 1'b1;
    tick();
    bus.rx_ack = 1'b0;
    exp_dr = 1'b0;
    exp_ov = 1'b0;
    check({tag, ".ack_dr"}, 32'(bus.data_ready), 32'(exp_dr));
    check({tag, ".ack_ov"}, 32'(bus.overrun_error), 32'(exp_ov));
  endtask

  // Drive one ideal frame; line goes low just before edge 0 of the frame.
  // The frame completes at edge DONE_EDGE; optional ack lands on that edge.
  task automatic send_frame(input string tag, input logic [DB-1:0] b, input logic stop,
                            input logic ack_done, input int extra_low);
    logic [9:0] line;
    line = {stop, b, 1'b0};
    for (int t = 0; t < 10 * int'(OS); t++) begin
      bus.rx     = line[t / int'(OS)];
      bus.rx_ack = (t == int'(DONE_EDGE)) ? ack_done : 1'b0;
      if (t == int'(DONE_EDGE)) begin
        check({tag, ".pre_dr"},   32'(bus.data_ready), 32'(exp_dr));
        check({tag, ".pre_busy"}, 32'(bus.rx_busy), 32'd1);
      end
      tick();
      if (t == int'(DONE_EDGE)) begin
        exp_ov   = exp_dr && !ack_done;
        exp_dr   = 1'b1;
        exp_data = b;
        exp_fe   = !stop;
        check_outputs({tag, ".done"});
        check({tag, ".busy"}, 32'(bus.rx_busy), 32'(!stop));
      end
    end
    bus.rx_ack = 1'b0;
    if (!stop) begin
      repeat (extra_low) tick();
      check({tag, ".brk_busy"}, 32'(bus.rx_busy), 32'd1);
      bus.rx = 1'b1;
      repeat (4) tick();
      check({tag, ".brk_idle"}, 32'(bus.rx_busy), 32'd0);
      check_outputs({tag, ".brk_out"});
    end
    bus.rx = 1'b1;
  endtask

  initial begin
    logic [DB-1:0] rb;
    logic          rstop;
    logic          rack;

    RST        = 1'b1;
    bus.rx     = 1'b1;
    bus.rx_ack = 1'b0;
    model_reset();
    repeat (3) tick();
    check_outputs("reset");
    check("reset.busy", 32'(bus.rx_busy), 32'd0);
    RST = 1'b0;
    repeat (3) tick();

    // Ideal 0xA5 frame; pre-check at edge DONE_EDGE-1 pins the latency.
    send_frame("a5", 8'hA5, 1'b1, 1'b0, 0);
    repeat (4) tick();

    // Short low glitch: busy pulses, nothing published.
    bus.rx = 1'b0;
    repeat (5) tick();
    check("glitch.busy_on", 32'(bus.rx_busy), 32'd1);
    bus.rx = 1'b1;
    repeat (15) tick();
    check("glitch.busy_off", 32'(bus.rx_busy), 32'd0);
    check_outputs("glitch");

    // Bad stop bit followed by a held-low line.
    do_ack("fe");
    send_frame("fe3c", 8'h3C, 1'b0, 1'b0, 40);
    repeat (4) tick();

    // Overrun: two frames without acknowledge, then clear.
    do_ack("ov_pre");
    send_frame("ov11", 8'h11, 1'b1, 1'b0, 0);
    repeat (3) tick();
    send_frame("ov22", 8'h22, 1'b1, 1'b0, 0);
    repeat (3) tick();
    check("ov.flag", 32'(bus.overrun_error), 32'd1);
    do_ack("ov_clr");

    // Acknowledge coinciding with completion of a second frame.
    send_frame("ac33", 8'h33, 1'b1, 1'b0, 0);
    repeat (2) tick();
    send_frame("ac44", 8'h44, 1'b1, 1'b1, 0);
    repeat (2) tick();
    check_outputs("ack_same");

    // Reset during bit 4, then a clean frame.
    bus.rx = 1'b0;
    repeat (OS) tick();
    for (int i = 0; i < 4; i++) begin
      bus.rx = 1'(i % 2);
      repeat (OS) tick();
    end
    bus.rx = 1'b1;
    repeat (OS / 2) tick();
    RST = 1'b1;
    model_reset();
    #2;
    check_outputs("rst_async");
    check("rst_async.busy", 32'(bus.rx_busy), 32'd0);
    repeat (3) tick();
    RST = 1'b0;
    repeat (4) tick();
    send_frame("r5a", 8'h5A, 1'b1, 1'b0, 0);
    repeat (4) tick();

    // Randomized frames, stop bits and acknowledge timing.
    for (int i = 0; i < 8; i++) begin
      rb    = DB'($urandom);
      rstop = ($urandom_range(0, 3) != 0);
      rack  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) do_ack("rnd_pre");
      send_frame("rnd", rb, rstop, rack, int'($urandom_range(2, 30)));
      repeat ($urandom_range(2, 8)) tick();
      check_outputs("rnd_gap");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
